// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Holds the MEM/WB register, selects the
// writeback value, owns the register file with bypassing read ports, drives the
// forwarding bus to execute, and tracks the retired count and HALT state.
module writeback_stage #(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    parameter int PCW   = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     valid_in,
    input  logic [DW-1:0]            alu_in,
    input  logic [PCW-1:0]           pc1_in,
    input  logic [1:0]               wb_sel_in,
    input  logic                     wb_en_in,
    input  logic [$clog2(NREGS)-1:0] wb_reg_in,
    input  logic                     halt_in,
    input  logic [DW-1:0]            mem_rdata,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [DW-1:0]            rd_data_a,
    output logic [DW-1:0]            rd_data_b,
    output logic                     fwd_valid,
    output logic [$clog2(NREGS)-1:0] fwd_reg,
    output logic [DW-1:0]            fwd_data,
    output logic [15:0]              retired,
    output logic                     halted
);

    localparam int AW = $clog2(NREGS);

    // MEM/WB pipeline register
    logic           wb_valid_q, wb_valid_d;
    logic [DW-1:0]  wb_alu_q,   wb_alu_d;
    logic [PCW-1:0] wb_pc1_q,   wb_pc1_d;
    logic [1:0]     wb_sel_q,   wb_sel_d;
    logic           wb_en_q,    wb_en_d;
    logic [AW-1:0]  wb_reg_q,   wb_reg_d;
    logic           wb_halt_q,  wb_halt_d;

    // Architectural state
    logic [DW-1:0]  rf_q [NREGS];
    logic [15:0]    retired_q, retired_d;
    logic           halted_q,  halted_d;

    logic           commit;
    logic           rf_we;
    logic [DW-1:0]  wb_data;

    // An instruction leaves WB only when not stalled and the machine is live;
    // a stalled instruction therefore commits exactly once, when stall drops.
    assign commit = wb_valid_q & ~stall & ~halted_q;
    assign rf_we  = commit & wb_en_q & ~wb_halt_q;

    // Writeback value select; load data arrives unregistered, aligned to WB.
    always_comb begin
        wb_data = '0;
        case (wb_sel_q)
            2'b00:   wb_data = mem_rdata;
            2'b01:   wb_data = wb_alu_q;
            2'b10:   wb_data = {{(DW-PCW){1'b0}}, wb_pc1_q};
            default: wb_data = '0;
        endcase
    end

    // Next-state for the pipeline register: capture when not stalled, else hold.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_alu_d   = wb_alu_q;
        wb_pc1_d   = wb_pc1_q;
        wb_sel_d   = wb_sel_q;
        wb_en_d    = wb_en_q;
        wb_reg_d   = wb_reg_q;
        wb_halt_d  = wb_halt_q;
        if (!stall) begin
            wb_valid_d = valid_in;
            wb_alu_d   = alu_in;
            wb_pc1_d   = pc1_in;
            wb_sel_d   = wb_sel_in;
            wb_en_d    = wb_en_in;
            wb_reg_d   = wb_reg_in;
            wb_halt_d  = halt_in;
        end
    end

    // Next-state for retired count (wraps) and the sticky halted flag.
    always_comb begin
        retired_d = retired_q;
        halted_d  = halted_q;
        if (commit) begin
            retired_d = retired_q + 16'd1;
            if (wb_halt_q) begin
                halted_d = 1'b1;
            end
        end
    end

    // Pipeline register, counter and halt flag state update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_alu_q   <= '0;
            wb_pc1_q   <= '0;
            wb_sel_q   <= '0;
            wb_en_q    <= 1'b0;
            wb_reg_q   <= '0;
            wb_halt_q  <= 1'b0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_alu_q   <= wb_alu_d;
            wb_pc1_q   <= wb_pc1_d;
            wb_sel_q   <= wb_sel_d;
            wb_en_q    <= wb_en_d;
            wb_reg_q   <= wb_reg_d;
            wb_halt_q  <= wb_halt_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
        end
    end

    // Register file: cleared on reset, one committing write per edge; R0 is ordinary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[wb_reg_q] <= wb_data;
        end
    end

    // Read ports with write-through bypass so a committing value is visible this cycle.
    always_comb begin
        rd_data_a = rf_q[rd_addr_a];
        rd_data_b = rf_q[rd_addr_b];
        if (rf_we && (wb_reg_q == rd_addr_a)) begin
            rd_data_a = wb_data;
        end
        if (rf_we && (wb_reg_q == rd_addr_b)) begin
            rd_data_b = wb_data;
        end
    end

    // Forwarding bus: not gated by stall so execute can consume a held result;
    // payload is zeroed whenever it carries nothing.
    always_comb begin
        fwd_valid = wb_valid_q & wb_en_q & ~wb_halt_q & ~halted_q;
        fwd_reg   = '0;
        fwd_data  = '0;
        if (fwd_valid) begin
            fwd_reg  = wb_reg_q;
            fwd_data = wb_data;
        end
    end

    assign retired = retired_q;
    assign halted  = halted_q;

endmodule
